// File: rtl/parity_frame_tx.sv
// -----------------------------------------------------------------------------
// parity_frame_tx
//
// Serial frame transmitter that sits after an 8-bit even-parity generator.
// It accepts a byte and its parity bit over a valid/ready handshake. It then
// drives a single-wire line with this frame:
//     start(0), d[0] .. d[7] (LSB first), parity, stop(1)
// Each bit is held for CLKS_PER_BIT clock cycles, so a frame lasts exactly
// 11*CLKS_PER_BIT cycles. The line idles high.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 1)
//   ODD_PARITY    1: transmit ~parity_in, 0: transmit parity_in unchanged
//
// Optional feature (compile-time macro PARITY_SELFCHECK_EN)
//   When defined, the block recomputes ^data_in on accept and compares it
//   with parity_in. par_err is registered, and holds until the next accept
//   or reset. The frame is still sent with the supplied parity.
//   When undefined, par_err is tied low and no check logic exists.
//
// Ports
//   clk        in   1  single clock, rising edge
//   rst_n      in   1  synchronous reset, active-low
//   data_in    in   8  byte to send, sampled on accept
//   parity_in  in   1  parity bit from upstream, sampled on accept
//   valid      in   1  upstream has byte+parity available
//   ready      out  1  block can accept (high only in IDLE)
//   tx         out  1  serial line, idles high
//   busy       out  1  frame in progress (cycle after accept .. last stop cycle)
//   par_err    out  1  parity self-check flag
// -----------------------------------------------------------------------------
module parity_frame_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit ODD_PARITY   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       parity_in,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       par_err
);

    // The baud counter needs at least one bit, even when CLKS_PER_BIT is 1.
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;

    logic accept;
    logic bit_end;

    assign accept  = valid && (state_q == S_IDLE);
    // With CLKS_PER_BIT == 1, BAUD_LAST is 0, so every cycle is a bit boundary.
    assign bit_end = (baud_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        bit_d   = bit_q;
        baud_d  = '0;

        // The baud counter only runs inside a frame. It restarts at every bit boundary.
        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    shift_d = data_in;
                    par_d   = parity_in ^ ODD_PARITY;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    // The 3-bit counter wraps from 7 to 0 as the last data bit leaves.
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            baud_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
        end
    end

    // Outputs are decoded from registered state only. No input reaches an output combinationally.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            S_START:  tx = 1'b0;
            S_DATA:   tx = shift_q[0];
            S_PARITY: tx = par_q;
            default:  tx = 1'b1;
        endcase
    end

    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q != S_IDLE);

`ifdef PARITY_SELFCHECK_EN
    logic par_err_q, par_err_d;

    always_comb begin
        par_err_d = par_err_q;
        if (accept) begin
            par_err_d = ((^data_in) != parity_in);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_parity_frame_tx.sv
module tb_parity_frame_tx;

`ifdef PARITY_SELFCHECK_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // dut0: CLKS_PER_BIT=4, even (pass-through) parity
    logic [7:0] data0 = '0;
    logic       par0 = 1'b0;
    logic       valid0 = 1'b0;
    logic       ready0, tx0, busy0, perr0;

    // dut1: CLKS_PER_BIT=1 boundary, odd parity
    logic [7:0] data1 = '0;
    logic       par1 = 1'b0;
    logic       valid1 = 1'b0;
    logic       ready1, tx1, busy1, perr1;

    int  passed = 0;
    int  total  = 0;
    bit  started = 1'b0;
    bit  q0[$];
    bit  q1[$];

    always #5 clk = ~clk;

    parity_frame_tx #(.CLKS_PER_BIT(4), .ODD_PARITY(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(data0), .parity_in(par0), .valid(valid0),
        .ready(ready0), .tx(tx0), .busy(busy0), .par_err(perr0)
    );

    parity_frame_tx #(.CLKS_PER_BIT(1), .ODD_PARITY(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data1), .parity_in(par1), .valid(valid1),
        .ready(ready1), .tx(tx1), .busy(busy1), .par_err(perr1)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Expected line image: start, d[0..7], parity^odd, stop; each repeated c times.
    task automatic push_frame(input int which, input logic [7:0] d, input logic p,
                              input int c, input logic odd);
        bit bits [11];
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        bits[9]  = p ^ odd;
        bits[10] = 1'b1;
        for (int b = 0; b < 11; b++)
            for (int k = 0; k < c; k++)
                if (which == 0) q0.push_back(bits[b]); else q1.push_back(bits[b]);
    endtask

    // Monitor: every busy cycle consumes one expected line value; idle line must be 1.
    always @(negedge clk) begin
        if (started) begin
            if (busy0) begin
                if (q0.size() == 0) begin
                    total++;
                    $display("FAIL dut0 tx: got busy cycle tx=%b, expected idle", tx0);
                end else chk("dut0 tx", tx0, q0.pop_front());
            end else chk("dut0 idle tx", tx0, 1'b1);
            if (busy1) begin
                if (q1.size() == 0) begin
                    total++;
                    $display("FAIL dut1 tx: got busy cycle tx=%b, expected idle", tx1);
                end else chk("dut1 tx", tx1, q1.pop_front());
            end else chk("dut1 idle tx", tx1, 1'b1);
        end
    end

    // All tasks below are entered and left at #1 after a rising edge.
    task automatic send0(input logic [7:0] d, input logic p, input bit hold, input logic exp_err);
        int n = 0;
        while (!ready0 && n < 200) begin @(posedge clk); #1; n++; end
        if (!ready0) begin total++; $display("FAIL dut0 ready wait: got timeout, expected ready"); end
        data0 = d; par0 = p; valid0 = 1'b1;
        @(posedge clk); #1;
        push_frame(0, d, p, 4, 1'b0);
        $display("dut0 send data=%02h parity=%b", d, p);
        chk("dut0 busy after accept", busy0, 1'b1);
        chk("dut0 par_err after accept", perr0, exp_err);
        if (!hold) valid0 = 1'b0;
    endtask

    task automatic wait_idle0();
        int n = 0;
        while (!ready0 && n < 200) begin @(posedge clk); #1; n++; end
        if (!ready0) begin total++; $display("FAIL dut0 idle wait: got timeout, expected ready"); end
    endtask

    initial begin
        // 1 reset
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        started = 1'b1;
        chk("reset tx", tx0, 1'b1);
        chk("reset ready", ready0, 1'b1);
        chk("reset busy", busy0, 1'b0);
        chk("reset par_err", perr0, 1'b0);
        chk("reset dut1 ready", ready1, 1'b1);

        // 2 A5 with parity 0: ready returns 44 cycles after tx falls
        send0(8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (43) @(posedge clk);
        #1;
        chk("A5 last stop cycle ready", ready0, 1'b0);
        @(posedge clk); #1;
        chk("A5 ready after frame", ready0, 1'b1);

        // 3 odd parity, CLKS_PER_BIT=1: 01 with parity 1 sends parity bit 0
        data1 = 8'h01; par1 = 1'b1; valid1 = 1'b1;
        @(posedge clk); #1;
        push_frame(1, 8'h01, 1'b1, 1, 1'b1);
        $display("dut1 send data=01 parity=1");
        valid1 = 1'b0;
        chk("dut1 tx falls after accept", tx1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("dut1 last stop cycle ready", ready1, 1'b0);
        @(posedge clk); #1;
        chk("dut1 ready after 11 cycles", ready1, 1'b1);

        // 4 back-to-back FF then 00 with valid held high
        send0(8'hFF, 1'b0, 1'b1, 1'b0);
        data0 = 8'h00; par0 = 1'b0;
        repeat (44) @(posedge clk);
        #1;
        chk("b2b gap ready", ready0, 1'b1);
        chk("b2b gap tx", tx0, 1'b1);
        @(posedge clk); #1;
        push_frame(0, 8'h00, 1'b0, 4, 1'b0);
        $display("dut0 send data=00 parity=0 (back-to-back)");
        valid0 = 1'b0;
        chk("b2b second start ready", ready0, 1'b0);
        chk("b2b second start tx", tx0, 1'b0);
        wait_idle0();

        // 5 reset during data bit 3, then a clean 3C frame
        send0(8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (17) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        q0.delete();
        rst_n = 1'b1;
        $display("dut0 reset mid-frame");
        chk("midreset tx", tx0, 1'b1);
        chk("midreset ready", ready0, 1'b1);
        chk("midreset busy", busy0, 1'b0);
        send0(8'h3C, 1'b0, 1'b0, 1'b0);
        wait_idle0();

        // 6 parity self-check: 07 has odd weight
        send0(8'h07, 1'b0, 1'b0, SC);
        wait_idle0();
        chk("par_err holds", perr0, SC);
        send0(8'h07, 1'b1, 1'b0, 1'b0);
        wait_idle0();

        repeat (4) @(posedge clk);
        #1;
        chk_int("dut0 queue drained", q0.size(), 0);
        chk_int("dut1 queue drained", q1.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
